// File: rtl/xc20xx_config_loader.sv
// xc20xx_config_loader
//   Serial configuration loader. Hunts a 0010 preamble in a 1-bit stream,
//   captures a 24-bit length count, checks the 1111 separator and per-frame
//   start/stop framing, and writes one parallel frame per strobe toward the
//   frame-addressed configuration store.
// Ports:
//   K          clock (rising edge)
//   R_N        asynchronous active-low reset
//   DIN        serial configuration bit, MSB first
//   DIN_EN     DIN is accepted only on edges where this is high
//   FRAME_DATA last completed frame (first data bit received in the MSB)
//   FRAME_ADDR 0-based index of the frame in FRAME_DATA
//   FRAME_WE   one-cycle write strobe for FRAME_DATA/FRAME_ADDR
//   BUSY       high from preamble detect until DONE or ERR
//   DONE       sticky: all frames loaded and length verified
//   ERR        sticky: framing or length error
module xc20xx_config_loader #(
  parameter int FRAME_BITS = 46,
  parameter int NUM_FRAMES = 160,
  parameter int ADDR_W     = 8
) (
  input  logic                  K,
  input  logic                  R_N,
  input  logic                  DIN,
  input  logic                  DIN_EN,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int BC_W = $clog2(FRAME_BITS + 4);
  localparam logic [BC_W-1:0]   SEP_LAST  = BC_W'(3);
  localparam logic [BC_W-1:0]   STOP_LAST = BC_W'(2);
  localparam logic [BC_W-1:0]   DATA_LAST = BC_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_HUNT, ST_LEN, ST_SEP, ST_START, ST_DATA, ST_STOP, ST_DONE, ST_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            hist_q, hist_d;
  logic [23:0]           cnt_q, cnt_d;
  logic [23:0]           len_q, len_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [FRAME_BITS-1:0] fdata_q, fdata_d;
  logic [ADDR_W-1:0]     faddr_q, faddr_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [23:0] cnt_inc;
  logic        last_frame;
  logic        overrun;
  logic        bad_bit;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    fdata_d    = fdata_q;
    faddr_d    = faddr_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_inc    = cnt_q + 24'd1;
    last_frame = (idx_q == LAST_IDX);
    overrun    = 1'b0;
    bad_bit    = 1'b0;

    if (DIN_EN) begin
      case (state_q)
        // The preamble is recognised from the registered history, so the
        // detecting edge is the one accepting the first length bit; that
        // bit is counted as bit 1.
        ST_HUNT: begin
          if (hist_q == 4'b0010) begin
            state_d   = ST_LEN;
            busy_d    = 1'b1;
            cnt_d     = 24'd1;
            len_d     = {23'd0, DIN};
            idx_d     = '0;
            bit_cnt_d = '0;
          end else begin
            hist_d = {hist_q[2:0], DIN};
          end
        end
        ST_LEN: begin
          cnt_d = cnt_inc;
          len_d = {len_q[22:0], DIN};
          if (cnt_inc == 24'd24) begin
            state_d   = ST_SEP;
            bit_cnt_d = '0;
          end
        end
        ST_SEP: begin
          cnt_d   = cnt_inc;
          overrun = (cnt_inc == len_q);
          if (!DIN) begin
            bad_bit = 1'b1;
          end else if (bit_cnt_q == SEP_LAST) begin
            state_d = ST_START;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        ST_START: begin
          cnt_d   = cnt_inc;
          overrun = (cnt_inc == len_q);
          if (DIN) begin
            bad_bit = 1'b1;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          cnt_d   = cnt_inc;
          overrun = (cnt_inc == len_q);
          shift_d = {shift_q[FRAME_BITS-2:0], DIN};
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        ST_STOP: begin
          cnt_d = cnt_inc;
          // The final frame's stop bits are the tail of the stream, so the
          // length is judged on its last stop bit rather than as overrun.
          overrun = (cnt_inc == len_q) && !last_frame;
          if (!DIN) begin
            bad_bit = 1'b1;
          end else if (bit_cnt_q == STOP_LAST) begin
            we_d    = 1'b1;
            fdata_d = shift_q;
            faddr_d = idx_q;
            idx_d   = idx_q + ADDR_W'(1);
            if (last_frame) begin
              busy_d = 1'b0;
              if (cnt_inc == len_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ERR;
                err_d   = 1'b1;
              end
            end else begin
              state_d = ST_START;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        default: begin
        end
      endcase

      // Any error cancels a pending frame write so no partial frame escapes.
      if (bad_bit || overrun) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        fdata_d = fdata_q;
        faddr_d = faddr_q;
        idx_d   = idx_q;
      end
    end
  end

  always_ff @(posedge K or negedge R_N) begin
    if (!R_N) begin
      state_q   <= ST_HUNT;
      hist_q    <= 4'b1111;
      cnt_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      fdata_q   <= '0;
      faddr_q   <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      fdata_q   <= fdata_d;
      faddr_q   <= faddr_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign FRAME_DATA = fdata_q;
  assign FRAME_ADDR = faddr_q;
  assign FRAME_WE   = we_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_xc20xx_config_loader.sv
// Bench for xc20xx_config_loader with a small configuration:
// 4 data bits per frame, 2 frames, 2-bit frame address.
module tb_xc20xx_config_loader;

  localparam int FB = 4;
  localparam int NF = 2;
  localparam int AW = 2;

  logic          K;
  logic          R_N;
  logic          DIN;
  logic          DIN_EN;
  logic [FB-1:0] FRAME_DATA;
  logic [AW-1:0] FRAME_ADDR;
  logic          FRAME_WE;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  xc20xx_config_loader #(
    .FRAME_BITS (FB),
    .NUM_FRAMES (NF),
    .ADDR_W     (AW)
  ) dut (
    .K          (K),
    .R_N        (R_N),
    .DIN        (DIN),
    .DIN_EN     (DIN_EN),
    .FRAME_DATA (FRAME_DATA),
    .FRAME_ADDR (FRAME_ADDR),
    .FRAME_WE   (FRAME_WE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  initial begin
    K = 1'b0;
    forever #5 K = ~K;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [23:0] len;
    logic [2:0]  stop0;
    logic        start1;
    logic        tog;
    logic        noise;
    int          exp_we;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t          vecs[8];
  int            total = 0;
  int            bad   = 0;
  bit            stream_q[$];
  logic [AW-1:0] cap_addr[$];
  logic [FB-1:0] cap_data[$];
  int            wide_we = 0;
  logic          prev_we = 1'b0;
  logic [FB-1:0] exp_frame[NF];

  // Strobe monitor: captures every write and counts strobes wider than a cycle.
  always @(negedge K) begin
    if (FRAME_WE === 1'b1) begin
      cap_addr.push_back(FRAME_ADDR);
      cap_data.push_back(FRAME_DATA);
      if (prev_we === 1'b1) wide_we++;
    end
    prev_we = FRAME_WE;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    R_N    = 1'b0;
    DIN_EN = 1'b0;
    DIN    = 1'b0;
    repeat (2) @(posedge K);
    #1;
    R_N = 1'b1;
  endtask

  task automatic build(input logic [23:0] len, input logic [2:0] stop0,
                       input logic start1, input logic noise);
    logic [8:0] nz;
    logic [7:0] hp;
    logic [3:0] f0;
    logic [3:0] f1;
    nz = 9'b111011001;
    hp = 8'b11110010;
    f0 = exp_frame[0];
    f1 = exp_frame[1];
    stream_q.delete();
    if (noise) for (int i = 8; i >= 0; i--) stream_q.push_back(nz[i]);
    for (int i = 7; i >= 0; i--) stream_q.push_back(hp[i]);
    for (int i = 23; i >= 0; i--) stream_q.push_back(len[i]);
    for (int i = 0; i < 4; i++) stream_q.push_back(1'b1);
    stream_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) stream_q.push_back(f0[i]);
    for (int i = 2; i >= 0; i--) stream_q.push_back(stop0[i]);
    stream_q.push_back(start1);
    for (int i = 3; i >= 0; i--) stream_q.push_back(f1[i]);
    for (int i = 0; i < 3; i++) stream_q.push_back(1'b1);
  endtask

  // Bits [a,b) of stream_q, one per accepted edge; with tog an idle cycle
  // carrying an inverted DIN follows every accepted bit.
  task automatic send_range(input int a, input int b, input logic tog);
    for (int i = a; i < b; i++) begin
      DIN    = stream_q[i];
      DIN_EN = 1'b1;
      @(posedge K);
      #1;
      if (tog) begin
        DIN_EN = 1'b0;
        DIN    = ~DIN;
        @(posedge K);
        #1;
      end
    end
    DIN_EN = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int a0;
    int w0;
    do_reset();
    build(v.len, v.stop0, v.start1, v.noise);
    a0 = cap_addr.size();
    w0 = wide_we;
    send_range(0, stream_q.size(), v.tog);
    repeat (4) @(posedge K);
    #1;
    check({v.name, " writes"}, 64'(cap_addr.size() - a0), 64'(v.exp_we));
    for (int k = 0; k < v.exp_we; k++) begin
      if (a0 + k < cap_addr.size()) begin
        check({v.name, " addr"}, 64'(cap_addr[a0+k]), 64'(k));
        check({v.name, " data"}, 64'(cap_data[a0+k]), 64'(exp_frame[k]));
      end
    end
    check({v.name, " done"}, 64'(DONE), 64'(v.exp_done));
    check({v.name, " err"},  64'(ERR),  64'(v.exp_err));
    check({v.name, " busy"}, 64'(BUSY), 64'(0));
    check({v.name, " strobe width"}, 64'(wide_we - w0), 64'(0));
  endtask

  initial begin
    exp_frame[0] = 4'b1010;
    exp_frame[1] = 4'b0110;
    //          name          len    stop0   st1   tog   noise we done err
    vecs[0] = '{"nominal",   24'd44, 3'b111, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    vecs[1] = '{"en_toggle", 24'd44, 3'b111, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    vecs[2] = '{"noise",     24'd44, 3'b111, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0};
    vecs[3] = '{"len43",     24'd43, 3'b111, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    vecs[4] = '{"len40",     24'd40, 3'b111, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[5] = '{"stop110",   24'd44, 3'b110, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[6] = '{"start1",    24'd44, 3'b111, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[7] = '{"len45",     24'd45, 3'b111, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1};

    R_N    = 1'b1;
    DIN    = 1'b0;
    DIN_EN = 1'b0;
    #2 R_N = 1'b0;
    #1;
    check("reset data", 64'(FRAME_DATA), 64'(0));
    check("reset addr", 64'(FRAME_ADDR), 64'(0));
    check("reset we",   64'(FRAME_WE),   64'(0));
    check("reset busy", 64'(BUSY),       64'(0));
    check("reset done", 64'(DONE),       64'(0));
    check("reset err",  64'(ERR),        64'(0));
    @(posedge K);
    #1;
    R_N = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // BUSY rises on the edge after the final preamble 0; DONE with last strobe.
    do_reset();
    build(24'd44, 3'b111, 1'b0, 1'b0);
    send_range(0, 8, 1'b0);
    check("busy after preamble", 64'(BUSY), 64'(0));
    send_range(8, 9, 1'b0);
    check("busy next edge", 64'(BUSY), 64'(1));
    send_range(9, 51, 1'b0);
    check("done before last bit", 64'(DONE), 64'(0));
    check("busy before last bit", 64'(BUSY), 64'(1));
    send_range(51, 52, 1'b0);
    check("done on last bit", 64'(DONE),       64'(1));
    check("we on last bit",   64'(FRAME_WE),   64'(1));
    check("addr on last bit", 64'(FRAME_ADDR), 64'(1));
    check("busy on last bit", 64'(BUSY),       64'(0));

    // L=40: counter reaches L on the third data bit of frame 1.
    do_reset();
    build(24'd40, 3'b111, 1'b0, 1'b0);
    send_range(0, 47, 1'b0);
    check("len40 err before", 64'(ERR),  64'(0));
    check("len40 busy before", 64'(BUSY), 64'(1));
    send_range(47, 48, 1'b0);
    check("len40 err at overrun",  64'(ERR),  64'(1));
    check("len40 busy at overrun", 64'(BUSY), 64'(0));

    // Reset while frame 0's strobe is high.
    do_reset();
    build(24'd44, 3'b111, 1'b0, 1'b0);
    send_range(0, 44, 1'b0);
    check("strobe0 we",   64'(FRAME_WE),   64'(1));
    check("strobe0 data", 64'(FRAME_DATA), 64'(4'b1010));
    #2 R_N = 1'b0;
    #1;
    check("rst in strobe we",   64'(FRAME_WE),   64'(0));
    check("rst in strobe data", 64'(FRAME_DATA), 64'(0));
    @(posedge K);
    #1;

    // Reset mid-DATA of frame 1, then a fresh full load.
    do_reset();
    build(24'd44, 3'b111, 1'b0, 1'b0);
    send_range(0, 47, 1'b0);
    check("mid busy", 64'(BUSY),       64'(1));
    check("mid data", 64'(FRAME_DATA), 64'(4'b1010));
    #2 R_N = 1'b0;
    #1;
    check("rst mid data", 64'(FRAME_DATA), 64'(0));
    check("rst mid addr", 64'(FRAME_ADDR), 64'(0));
    check("rst mid we",   64'(FRAME_WE),   64'(0));
    check("rst mid busy", 64'(BUSY),       64'(0));
    check("rst mid done", 64'(DONE),       64'(0));
    check("rst mid err",  64'(ERR),        64'(0));
    @(posedge K);
    #1;
    run_vec('{"after_reset", 24'd44, 3'b111, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xc20xx_config_loader.md
# xc20xx_config_loader

Serial configuration loader for the XC20XX fabric model: the writer side of the CLB configuration it feeds. It accepts a bitstream one bit per enabled clock and hunts for the preamble. It then checks the length count and frame framing, and emits one parallel configuration frame per write strobe toward the configuration memory that drives CLB parameters such as LUT INIT, input muxes and storage-element mode. It sits between the external serial configuration pin and the frame-addressed configuration store.

## Interface
- FRAME_BITS, 46, data bits per frame
- NUM_FRAMES, 160, frames per bitstream
- ADDR_W, 8, width of FRAME_ADDR; must satisfy 2**ADDR_W >= NUM_FRAMES
- K  input  1  clock; all state changes on rising edge
- R_N  input  1  reset, asynchronous, active-low
- DIN  input  1  serial configuration bit
- DIN_EN  input  1  DIN is accepted only on rising K edges where DIN_EN=1
- FRAME_DATA  output  FRAME_BITS  last completed frame; the first data bit received lands in the MSB
- FRAME_ADDR  output  ADDR_W  index of the frame in FRAME_DATA, 0-based
- FRAME_WE  output  1  one-cycle write strobe for FRAME_DATA/FRAME_ADDR
- BUSY  output  1  high from preamble detect until DONE or ERR
- DONE  output  1  sticky; bitstream loaded and length verified
- ERR  output  1  sticky; framing or length error

## Operation
- Bitstream format, MSB first throughout:
  - leader of 1s;
  - preamble 0010;
  - 24-bit length count L;
  - separator 1111;
  - NUM_FRAMES frames, each made of start bit 0, FRAME_BITS data bits, and stop bits 111.
- Bit counter (24 bits) is cleared on preamble detect and increments on every accepted bit after it, starting with the first length bit.
- States: HUNT, LEN, SEP, START, DATA, STOP, DONE, ERR.
- HUNT: a 4-bit history shift register takes accepted bits. When the history equals 0010, go to LEN, set BUSY=1 and clear the counters. Any other pattern stays in HUNT.
- LEN: shift 24 bits into L, then go to SEP.
- SEP: expect four 1s, then go to START. Any 0 goes to ERR.
- START: a 0 goes to DATA. A 1 goes to ERR.
- DATA: shift exactly FRAME_BITS bits into the frame shift register, then go to STOP.
- STOP: expect three 1s. A 0 goes to ERR. On the third 1:
  - copy the shift register to FRAME_DATA, drive FRAME_ADDR with the frame index, and pulse FRAME_WE;
  - increment the frame index;
  - if the index reaches NUM_FRAMES, go to DONE if counter == L, otherwise go to ERR; else go back to START.
- Overrun: if the counter reaches L while any bits remain to be consumed, go to ERR.
- DONE and ERR are absorbing. BUSY=0 in both. Further DIN is ignored. Only reset leaves them.
- No partial frame is ever written. A frame that hits ERR during STOP produces no FRAME_WE.

## Timing
- Reset value of every output is 0. State is HUNT. The history register resets to 4'b1111, so leftover 0s cannot fake a preamble.
- R_N assertion mid-load aborts at once and asynchronously. FRAME_WE drops that instant. A frame not yet strobed is discarded.
- Cycles with DIN_EN=0 change nothing. FRAME_WE still deasserts after its single cycle.
- BUSY rises on the K edge after the edge that accepts the final preamble 0.
- FRAME_WE is high for exactly the one cycle after the edge that accepts the third stop bit. FRAME_DATA and FRAME_ADDR change on that same edge and hold until the next strobe.
- DONE and ERR rise on the same edge as the final FRAME_WE, or on the edge that accepts the offending bit.
- Back-to-back frames with DIN_EN held high give FRAME_WE every FRAME_BITS+4 cycles.
- Minimum full load: 4 + 24 + 4 + NUM_FRAMES·(FRAME_BITS+4) accepted bits after the leader.

## Test plan
- Nominal, with FRAME_BITS=4, NUM_FRAMES=2, L=44. Stimulus: 1111, 0010, L, 1111, 0 1010 111, 0 0110 111, DIN_EN=1 throughout.
  - Response: FRAME_WE pulses twice, with (addr 0, data 4'b1010) then (addr 1, data 4'b0110).
  - DONE=1 on the final strobe edge; ERR=0; BUSY 1→0.
- Same stream with DIN_EN toggling 1,0,1,0: identical frames and DONE. FRAME_WE is still a single cycle each time.
- Length mismatch, L=43: both frames are written, then ERR=1 and DONE=0. With L=40: ERR=1 during frame 1 DATA, and only frame 0 is written.
- Framing errors:
  - stop pattern 110 in frame 0 gives ERR, no FRAME_WE, BUSY=0;
  - start bit 1 in frame 1 gives ERR after exactly one strobe.
- Leader noise: 1110 1100 1 then 0010 preamble. No false detect happens before the real 0010. Result matches the nominal test.
- Reset mid-DATA of frame 1: all outputs are 0 immediately. A fresh full nominal stream afterward yields addresses 0 and 1 and DONE.
